// File: rtl/trace_cache_responder_if.sv
// Trace-command bus between the trace driver (master) and the cache responder (slave).
// Commands are offered on valid/n/address and taken only while ready is high.
interface trace_cache_responder_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              valid;
  logic [3:0]        n;
  logic [ADDR_W-1:0] address;
  logic              ready;
  logic              done;
  logic              last_hit;
  logic [CNT_W-1:0]  hit_cntr;
  logic [CNT_W-1:0]  miss_cntr;

  modport master (
    output valid, n, address,
    input  ready, done, last_hit, hit_cntr, miss_cntr
  );

  modport slave (
    input  valid, n, address,
    output ready, done, last_hit, hit_cntr, miss_cntr
  );
endinterface

// File: rtl/trace_cache_responder.sv
// Direct-mapped tag responder with saturating hit/miss counters; access done 2 cycles after accept, clear 1+SETS.
// One command in flight: ready drops on accept and returns the cycle after done; valid while busy is dropped.
module trace_cache_responder #(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 64,
  parameter int LINE_BYTES = 64,
  parameter int CNT_W      = 16
) (
  input logic                   clk,
  input logic                   rstb,
  trace_cache_responder_if.slave bus
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int TAG_W  = LINE_W - IDX_W;

  localparam logic [3:0] CMD_READ  = 4'd0;
  localparam logic [3:0] CMD_WRITE = 4'd1;
  localparam logic [3:0] CMD_FETCH = 4'd2;
  localparam logic [3:0] CMD_INV   = 4'd3;
  localparam logic [3:0] CMD_CLEAR = 4'd8;

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              hit_q, hit_d;
  logic              done_q, done_d;
  logic              last_hit_q, last_hit_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic [SETS-1:0]   vbit_q, vbit_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic [TAG_W-1:0]  tag_q [SETS];
  logic              tag_we;

  logic              ready;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;

  // Only the line address is latched; the byte offset never affects a lookup.
  assign idx   = line_q[IDX_W-1:0];
  assign tag   = line_q[LINE_W-1:IDX_W];
  assign ready = (state_q == IDLE) && !done_q;

  assign bus.ready     = ready;
  assign bus.done      = done_q;
  assign bus.last_hit  = last_hit_q;
  assign bus.hit_cntr  = hit_cnt_q;
  assign bus.miss_cntr = miss_cnt_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    line_d     = line_q;
    hit_d      = hit_q;
    done_d     = 1'b0;
    last_hit_d = last_hit_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    vbit_d     = vbit_q;
    clr_idx_d  = clr_idx_q;
    tag_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ready && bus.valid) begin
          cmd_d   = bus.n;
          line_d  = bus.address[ADDR_W-1:OFF_W];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d     = vbit_q[idx] && (tag_q[idx] == tag);
        clr_idx_d = '0;
        state_d   = (cmd_q == CMD_CLEAR) ? CLEAR : UPDATE;
      end
      UPDATE: begin
        case (cmd_q)
          CMD_READ, CMD_WRITE, CMD_FETCH: begin
            if (hit_q) begin
              if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end else begin
              if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt_q + CNT_W'(1);
              vbit_d[idx] = 1'b1;
              tag_we      = 1'b1;
            end
            last_hit_d = hit_q;
          end
          CMD_INV: begin
            if (hit_q) vbit_d[idx] = 1'b0;
          end
          default: ;
        endcase
        done_d  = 1'b1;
        state_d = IDLE;
      end
      CLEAR: begin
        vbit_d[clr_idx_q] = 1'b0;
        if (clr_idx_q == '0) begin
          hit_cnt_d  = '0;
          miss_cnt_d = '0;
        end
        if (clr_idx_q == IDX_W'(SETS - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      line_q     <= '0;
      hit_q      <= 1'b0;
      done_q     <= 1'b0;
      last_hit_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      vbit_q     <= '0;
      clr_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      line_q     <= line_d;
      hit_q      <= hit_d;
      done_q     <= done_d;
      last_hit_q <= last_hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      vbit_q     <= vbit_d;
      clr_idx_q  <= clr_idx_d;
    end
  end

  // Tag contents are meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[idx] <= tag;
  end
endmodule

// File: tb/tb_trace_cache_responder.sv
// Bench for trace_cache_responder: vector table plus scoreboard checked on every done pulse.
// Small counter width so saturation is reachable in a short run.
module tb_trace_cache_responder;
  localparam int ADDR_W = 32;
  localparam int SETS   = 64;
  localparam int LBYTES = 64;
  localparam int CNT_W  = 4;
  localparam int LAT    = 2;
  localparam int CLAT   = 1 + SETS;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct {
    logic last;
    int   hit;
    int   miss;
  } exp_t;

  typedef struct {
    logic [3:0]  n;
    logic [31:0] addr;
    logic        last;
    int          hit;
    int          miss;
  } vec_t;

  logic clk = 1'b0;
  logic rstb = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  vec_t tbl[14];

  trace_cache_responder_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  trace_cache_responder #(
    .ADDR_W(ADDR_W), .SETS(SETS), .LINE_BYTES(LBYTES), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rstb(rstb),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hit_cntr", 32'(bus.hit_cntr), 32'(e.hit));
        chk("miss_cntr", 32'(bus.miss_cntr), 32'(e.miss));
        chk("last_hit", 32'(bus.last_hit), 32'(e.last));
      end
    end
  end

  function automatic exp_t mk(input logic last, input int hit, input int miss);
    exp_t e;
    e.last = last;
    e.hit  = hit;
    e.miss = miss;
    return e;
  endfunction

  // Issues one command in the current (negedge) slot; valid is kept high with
  // junk n/address while busy to show those are ignored and not re-sampled.
  task automatic do_cmd(input logic [3:0] c, input logic [31:0] a, input int lat, input exp_t e);
    int  cyc;
    bit  seen;
    cyc = 0;
    while (bus.ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.ready !== 1'b1) chk("ready_wait", 32'(bus.ready), 32'd1);
    bus.valid   = 1'b1;
    bus.n       = c;
    bus.address = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.n       = 4'($urandom);
    bus.address = $urandom;
    @(negedge clk);
    chk("ready_busy", 32'(bus.ready), 32'd0);
    seen = 1'b0;
    cyc  = -1;
    for (int k = 1; k <= lat + 5 && !seen; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        cyc  = k;
      end
    end
    bus.valid = 1'b0;
    chk("done_latency", 32'(cyc), 32'(lat));
    chk("ready_in_done", 32'(bus.ready), 32'd0);
    @(negedge clk);
    chk("ready_after_done", 32'(bus.ready), 32'd1);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{4'd0, 32'h0000_1040, 1'b0, 0, 1};
    tbl[1]  = '{4'd2, 32'h0000_107C, 1'b1, 1, 1};
    tbl[2]  = '{4'd1, 32'h0000_2040, 1'b0, 1, 2};
    tbl[3]  = '{4'd0, 32'h0000_1040, 1'b0, 1, 3};
    tbl[4]  = '{4'd3, 32'h0000_1040, 1'b0, 1, 3};
    tbl[5]  = '{4'd0, 32'h0000_1040, 1'b0, 1, 4};
    tbl[6]  = '{4'd9, 32'h0000_1040, 1'b0, 1, 4};
    tbl[7]  = '{4'd0, 32'h0000_1040, 1'b1, 2, 4};
    tbl[8]  = '{4'd3, 32'h0000_3040, 1'b1, 2, 4};
    tbl[9]  = '{4'd1, 32'h0000_1000, 1'b0, 2, 5};
    tbl[10] = '{4'd0, 32'h0000_1040, 1'b1, 3, 5};
    tbl[11] = '{4'd7, 32'h0000_0000, 1'b1, 3, 5};
    tbl[12] = '{4'd0, 32'hFFFF_FFC0, 1'b0, 3, 6};
    tbl[13] = '{4'd2, 32'hFFFF_FFFF, 1'b1, 4, 6};

    bus.valid   = 1'b0;
    bus.n       = '0;
    bus.address = '0;
    repeat (3) @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_last_hit", 32'(bus.last_hit), 32'd0);
    chk("rst_hit_cntr", 32'(bus.hit_cntr), 32'd0);
    chk("rst_miss_cntr", 32'(bus.miss_cntr), 32'd0);

    for (int i = 0; i < 14; i++)
      do_cmd(tbl[i].n, tbl[i].addr, LAT, mk(tbl[i].last, tbl[i].hit, tbl[i].miss));

    // Clear keeps last_hit, zeroes counters and invalidates every line.
    do_cmd(4'd8, 32'h0000_1040, CLAT, mk(1'b1, 0, 0));
    do_cmd(4'd0, 32'h0000_1040, LAT, mk(1'b0, 0, 1));
    do_cmd(4'd2, 32'hFFFF_FFFF, LAT, mk(1'b0, 0, 2));

    for (int i = 0; i < 17; i++)
      do_cmd(4'd0, 32'h0000_1040, LAT, mk(1'b1, (i + 1 > CMAX) ? CMAX : i + 1, 2));

    for (int i = 0; i < 16; i++)
      do_cmd(4'd1, (i % 2 == 0) ? 32'h0000_2040 : 32'h0000_1040, LAT,
             mk(1'b0, CMAX, (i + 3 > CMAX) ? CMAX : i + 3));

    do_cmd(4'd0, 32'hFFFF_FFC0, LAT, mk(1'b1, CMAX, CMAX));

    // Reset lands in the middle of a clear sweep.
    bus.valid = 1'b1;
    bus.n     = 4'd8;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("clear_busy_ready", 32'(bus.ready), 32'd0);
    rstb = 1'b1;
    @(negedge clk);
    rstb = 1'b0;
    chk("midclr_ready", 32'(bus.ready), 32'd1);
    chk("midclr_done", 32'(bus.done), 32'd0);
    chk("midclr_hit_cntr", 32'(bus.hit_cntr), 32'd0);
    chk("midclr_miss_cntr", 32'(bus.miss_cntr), 32'd0);
    chk("midclr_last_hit", 32'(bus.last_hit), 32'd0);
    do_cmd(4'd0, 32'hFFFF_FFC0, LAT, mk(1'b0, 0, 1));
    do_cmd(4'd0, 32'h0000_1040, LAT, mk(1'b0, 0, 2));

    repeat (5) @(negedge clk);
    chk("idle_hit_cntr", 32'(bus.hit_cntr), 32'd0);
    chk("idle_miss_cntr", 32'(bus.miss_cntr), 32'd2);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/trace_cache_responder.md
Name: trace_cache_responder

Overview:
- Cache-side responder for the trace-command interface: accepts one command (`n`, `address`) per `valid` pulse.
- Performs a direct-mapped tag lookup/update on each accepted command and maintains the running `hit_cntr`/`miss_cntr` values read back by the trace checker.
- Sits between the trace driver and the cache statistics path.
- Provides a `ready`/`done` handshake so the driver can pace commands without a fixed wait.

Parameters:
- ADDR_W, 32, address width in bits.
- SETS, 64, number of direct-mapped lines; power of two, at least 2.
- LINE_BYTES, 64, line size in bytes; power of two; offset bits = log2(LINE_BYTES).
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rstb  in  1  reset; synchronous, active-high (1 = reset asserted).
- valid  in  1  command strobe; sampled only when ready=1.
- n  in  4  command code.
- address  in  ADDR_W  byte address.
- ready  out  1  1 = a command can be accepted this cycle.
- done  out  1  one-cycle pulse when a command completes.
- last_hit  out  1  result of the most recent counted access (1 = hit).
- hit_cntr  out  CNT_W  accumulated hits.
- miss_cntr  out  CNT_W  accumulated misses.

Behaviour:
- Address split: offset = low log2(LINE_BYTES) bits (ignored); index = next log2(SETS) bits; tag = remaining upper bits. Defaults give offset [5:0], index [11:6], tag [31:12].
- Storage: per-set valid bit and tag register.
- Reset (rstb=1 at a clk edge), with priority over everything including an in-progress CLEAR:
  - state = IDLE, ready=1, done=0, last_hit=0;
  - both counters 0;
  - all valid bits 0; tag contents don't-care.
- FSM states: IDLE, LOOKUP, UPDATE, CLEAR.
- IDLE:
  - ready=1.
  - If valid=1, latch n and address, drop ready, go to LOOKUP.
  - If valid=0, stay in IDLE.
- LOOKUP (1 cycle):
  - ready=0.
  - Compute hit = valid_bit[index] and tag_match.
  - Go to UPDATE, or to CLEAR when n=8.
- UPDATE (1 cycle), action by command code:
  - n = 0, 1 or 2 (read, write, instruction fetch): on hit, increment hit_cntr. On miss, increment miss_cntr, write the tag and set valid_bit[index]; any previous line in that set is overwritten. Set last_hit = hit.
  - n = 3 (invalidate): on hit, clear valid_bit[index]; no counter change; last_hit unchanged.
  - n = 9 (print) and all other codes: no state change.
  - In every case, assert done and return to IDLE.
- CLEAR:
  - Clear one valid bit per cycle, index 0 up to SETS-1, using an internal index counter.
  - Zero both counters in the first CLEAR cycle.
  - After the SETS-1 clear, assert done and return to IDLE.
  - Total CLEAR latency = SETS cycles after LOOKUP.
- Latency, counting the acceptance edge as cycle 0:
  - Counted access: done high in cycle 2; counters and last_hit updated at the same edge that raises done.
  - ready returns to 1 in cycle 3.
  - Clear (n=8): done high in cycle 1+SETS.
- valid while ready=0 is ignored and not queued. The driver must wait for done or ready.
- Counters saturate at 2^CNT_W-1; no wrap.
- done is exactly one cycle wide; it is never asserted in IDLE except on the return edge.
- Back-to-back commands: valid=1 in the first ready=1 cycle after done is accepted; no dead cycle required.
- Command code and address are held internally; input changes after acceptance have no effect.

Test Plan:
- Reset, then cmd n=0 addr 0x0000_1040 -> done at cycle 2; miss_cntr=1, hit_cntr=0, last_hit=0.
- Same line again, n=2 addr 0x0000_107C (same tag and index, different offset) -> hit_cntr=1, miss_cntr=1, last_hit=1.
- Conflict: n=1 addr 0x0000_2040 (same index 1, new tag), then n=0 addr 0x0000_1040 -> two misses; miss_cntr=3, hit_cntr=1.
- Invalidate: n=3 addr 0x0000_1040 -> counters unchanged; a following n=0 addr 0x0000_1040 -> miss_cntr+1.
- Clear: n=8 mid-run -> ready low for SETS+1 cycles, done at cycle 65, counters=0; next n=0 at any previously cached address -> miss.
- Reset mid-CLEAR (rstb=1 at clear cycle 10) -> next cycle state IDLE, ready=1, counters 0, all lines invalid. Also: valid pulsed while ready=0 -> ignored, counters unchanged.
